// File: rtl/mem_stage_hs.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_hs
// Brief    : Pipeline MEM stage with req/ack data-memory handshake, sub-word
//            lane steering, load extension and a stalling MEM/WB register.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage_hs #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int BE_W       = DATA_W / 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    input  logic                  i_flush,
    input  logic                  i_con_mem_read,
    input  logic                  i_con_mem_write,
    input  logic                  i_con_mem_branch,
    input  logic                  i_con_Zero,
    input  logic                  i_con_wb_memtoreg,
    input  logic                  i_con_wb_regwrite,
    input  logic [1:0]            i_size,
    input  logic                  i_unsigned,
    input  logic [DATA_W-1:0]     i_data_ALU_Rst,
    input  logic [DATA_W-1:0]     i_data_Store,
    input  logic [REG_ADDR_W-1:0] i_addr_MuxRst,
    output logic                  o_dmem_req,
    output logic                  o_dmem_we,
    output logic [DATA_W-1:0]     o_dmem_addr,
    output logic [DATA_W-1:0]     o_dmem_wdata,
    output logic [BE_W-1:0]       o_dmem_be,
    input  logic                  i_dmem_ack,
    input  logic [DATA_W-1:0]     i_dmem_rdata,
    output logic                  o_stall,
    output logic                  o_con_PCSrc,
    output logic                  o_misalign,
    output logic                  o_valid,
    output logic                  o_con_wb_memtoreg,
    output logic                  o_con_wb_regwrite,
    output logic [DATA_W-1:0]     o_data_Memory,
    output logic [DATA_W-1:0]     o_data_ALU_Rst,
    output logic [REG_ADDR_W-1:0] o_addr_MuxRst
);

    localparam int         LANE_W  = $clog2(BE_W);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [0:0]        r_state;
    logic [0:0]        w_state_next;
    logic              r_kill;

    logic [DATA_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [BE_W-1:0]   r_be;
    logic              r_we;
    logic              r_read;
    logic              r_unsigned;
    logic [1:0]        r_size;

    logic [2:0]        w_align_mask;
    logic              w_size_ok;
    logic              w_aligned;
    logic              w_mem_op;
    logic              w_live;
    logic              w_misalign;
    logic [BE_W-1:0]   w_be;
    logic [DATA_W-1:0] w_wdata;

    logic [LANE_W-1:0] w_cur_lane;
    logic [1:0]        w_cur_size;
    logic              w_cur_unsigned;
    logic [DATA_W-1:0] w_shift;
    logic              w_ext;
    logic [DATA_W-1:0] w_load;

    logic              w_wb_valid;
    logic              w_wb_regwrite;
    logic              w_load_capture;

    function automatic logic [BE_W-1:0] byte_mask(input logic [1:0] size);
        logic [BE_W-1:0] m;
        for (int i = 0; i < BE_W; i++) begin
            m[i] = (i < (1 << size));
        end
        return m;
    endfunction

    // ------------------------------------------------------------------------
    // Request decode. Dword accesses only exist on a 64-bit datapath; on a
    // 32-bit datapath they are rejected through the misalignment path.
    // ------------------------------------------------------------------------
    always_comb begin
        case (i_size)
            2'd0:    w_align_mask = 3'b000;
            2'd1:    w_align_mask = 3'b001;
            2'd2:    w_align_mask = 3'b011;
            default: w_align_mask = 3'b111;
        endcase
    end

    assign w_size_ok  = (i_size != 2'd3) || (DATA_W == 64);
    assign w_aligned  = w_size_ok && ((i_data_ALU_Rst[2:0] & w_align_mask) == 3'b000);
    assign w_mem_op   = i_valid & ~i_flush & (i_con_mem_read | i_con_mem_write);
    assign w_live     = w_mem_op & w_aligned;
    assign w_misalign = (r_state == ST_IDLE) & w_mem_op & ~w_aligned;

    assign w_be = byte_mask(i_size) << i_data_ALU_Rst[LANE_W-1:0];

    always_comb begin
        w_wdata = '0;
        for (int i = 0; i < BE_W; i++) begin
            w_wdata[i*8 +: 8] = i_data_Store[(i % (1 << i_size))*8 +: 8];
        end
    end

    // ------------------------------------------------------------------------
    // Load alignment: live fields for a zero-wait ack, latched ones in WAIT.
    // ------------------------------------------------------------------------
    assign w_cur_lane     = (r_state == ST_WAIT) ? r_addr[LANE_W-1:0]
                                                 : i_data_ALU_Rst[LANE_W-1:0];
    assign w_cur_size     = (r_state == ST_WAIT) ? r_size : i_size;
    assign w_cur_unsigned = (r_state == ST_WAIT) ? r_unsigned : i_unsigned;

    always_comb begin : load_align
        int nbits;
        w_shift = i_dmem_rdata >> {w_cur_lane, 3'b000};
        nbits   = 8 << w_cur_size;
        if (nbits > DATA_W) begin
            nbits = DATA_W;
        end
        w_ext  = ~w_cur_unsigned & w_shift[nbits-1];
        w_load = '0;
        for (int i = 0; i < DATA_W; i++) begin
            w_load[i] = (i < nbits) ? w_shift[i] : w_ext;
        end
    end

    // ------------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_live && !i_dmem_ack) w_state_next = ST_WAIT;
            ST_WAIT: if (i_dmem_ack)            w_state_next = ST_IDLE;
            default:                            w_state_next = ST_IDLE;
        endcase
    end

    // Outputs are gated by the reset pin so they drop without waiting for a clock.
    always_comb begin
        o_dmem_req   = 1'b0;
        o_stall      = 1'b0;
        o_misalign   = 1'b0;
        o_dmem_we    = 1'b0;
        o_dmem_be    = '0;
        o_dmem_addr  = i_data_ALU_Rst;
        o_dmem_wdata = w_wdata;
        if (i_rst_n) begin
            case (r_state)
                ST_IDLE: begin
                    o_dmem_req = w_live;
                    o_stall    = w_live & ~i_dmem_ack;
                    o_misalign = w_misalign;
                    o_dmem_we  = w_live & i_con_mem_write;
                    o_dmem_be  = w_live ? w_be : '0;
                end
                ST_WAIT: begin
                    o_dmem_req   = 1'b1;
                    o_stall      = ~i_dmem_ack;
                    o_dmem_we    = r_we;
                    o_dmem_be    = r_be;
                    o_dmem_addr  = r_addr;
                    o_dmem_wdata = r_wdata;
                end
                default: ;
            endcase
        end
    end

    assign o_con_PCSrc = i_rst_n & i_valid & ~i_flush & i_con_mem_branch & i_con_Zero;

    // ------------------------------------------------------------------------
    // Request latch and sticky kill for flushes arriving mid-transaction
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_be       <= '0;
            r_we       <= 1'b0;
            r_read     <= 1'b0;
            r_unsigned <= 1'b0;
            r_size     <= 2'd0;
            r_kill     <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && w_live && !i_dmem_ack) begin
                r_addr     <= i_data_ALU_Rst;
                r_wdata    <= w_wdata;
                r_be       <= w_be;
                r_we       <= i_con_mem_write;
                r_read     <= i_con_mem_read;
                r_unsigned <= i_unsigned;
                r_size     <= i_size;
            end
            if (r_state == ST_WAIT && !i_dmem_ack) begin
                r_kill <= r_kill | i_flush;
            end else begin
                r_kill <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // MEM/WB register
    // ------------------------------------------------------------------------
    assign w_wb_valid     = (r_state == ST_WAIT) ? ~(r_kill | i_flush) : (i_valid & ~i_flush);
    assign w_wb_regwrite  = i_con_wb_regwrite & w_wb_valid & ~w_misalign;
    assign w_load_capture = i_dmem_ack & ((r_state == ST_WAIT) ? r_read
                                                               : (w_live & i_con_mem_read));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid           <= 1'b0;
            o_con_wb_memtoreg <= 1'b0;
            o_con_wb_regwrite <= 1'b0;
            o_data_Memory     <= '0;
            o_data_ALU_Rst    <= '0;
            o_addr_MuxRst     <= '0;
        end else if (o_stall) begin
            o_valid           <= 1'b0;
            o_con_wb_regwrite <= 1'b0;
        end else begin
            o_valid           <= w_wb_valid;
            o_con_wb_regwrite <= w_wb_regwrite;
            o_con_wb_memtoreg <= i_con_wb_memtoreg;
            o_data_ALU_Rst    <= i_data_ALU_Rst;
            o_addr_MuxRst     <= i_addr_MuxRst;
            if (w_load_capture) begin
                o_data_Memory <= w_load;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/mem_stage_hs.md
MEM_STAGE_HS -- requirements
Module: mem_stage_hs

Interface
REQ-001 Parameters SHALL be: DATA_W, default 32, datapath width, 32 or 64 only; REG_ADDR_W, default 5, register address width; BE_W = DATA_W/8, derived, byte-enable width.
REQ-002 Ports SHALL be:
  i_clk  in  1  clock, rising edge.
  i_rst_n  in  1  reset, asynchronous, active-low.
  i_valid  in  1  EX/MEM slot holds a live instruction.
  i_flush  in  1  kill the instruction entering this stage.
  i_con_mem_read, i_con_mem_write, i_con_mem_branch, i_con_Zero  in  1 each  control and ALU zero flag.
  i_con_wb_memtoreg, i_con_wb_regwrite  in  1 each  WB controls.
  i_size  in  2  access size: 0 byte, 1 half, 2 word, 3 dword (dword only when DATA_W=64).
  i_unsigned  in  1  zero-extend loads.
  i_data_ALU_Rst  in  DATA_W  ALU result or byte address.
  i_data_Store  in  DATA_W  store data, right-aligned.
  i_addr_MuxRst  in  REG_ADDR_W  destination register.
  o_dmem_req, o_dmem_we  out  1 each  memory request and write strobe.
  o_dmem_addr  out  DATA_W  byte address.
  o_dmem_wdata  out  DATA_W  lane-replicated store data.
  o_dmem_be  out  BE_W  byte enables.
  i_dmem_ack  in  1  request accepted; read data valid this cycle.
  i_dmem_rdata  in  DATA_W  read data.
  o_stall  out  1  upstream SHALL hold its inputs.
  o_con_PCSrc  out  1  branch taken.
  o_misalign  out  1  one-cycle misaligned-access pulse.
  o_valid, o_con_wb_memtoreg, o_con_wb_regwrite  out  1 each  MEM/WB register.
  o_data_Memory, o_data_ALU_Rst  out  DATA_W each  MEM/WB register.
  o_addr_MuxRst  out  REG_ADDR_W  MEM/WB register.

Function
REQ-003 A live memory op SHALL be defined as i_valid & (i_con_mem_read | i_con_mem_write) & aligned; aligned SHALL mean the low address bits are zero modulo 2^i_size.
REQ-004 The FSM SHALL have two states, IDLE and WAIT.
  IDLE to WAIT: live memory op and !i_dmem_ack.
  WAIT to IDLE: i_dmem_ack.
REQ-005 In IDLE with a live memory op, o_dmem_req SHALL assert combinationally in the same cycle. Request fields SHALL be latched at that edge, and WAIT SHALL drive the latched fields, so they stay stable until ack.
REQ-006 o_stall SHALL equal (IDLE & live memory op & !i_dmem_ack) | (WAIT & !i_dmem_ack). A zero-wait ack SHALL therefore produce no stall.
REQ-007 o_dmem_be SHALL set 2^i_size contiguous bits starting at lane addr[log2(BE_W)-1:0]. o_dmem_wdata SHALL replicate the low 2^i_size bytes of i_data_Store across all lanes. o_dmem_we SHALL equal the latched mem_write.
REQ-008 Load data SHALL be the selected lane(s) of i_dmem_rdata, right-aligned, then sign-extended, or zero-extended when i_unsigned=1. It SHALL be captured into o_data_Memory on the ack edge.
REQ-009 A misaligned memory access SHALL issue no request and SHALL pulse o_misalign for one cycle. The instruction SHALL reach WB with o_valid=1 and o_con_wb_regwrite=0.
REQ-010 o_con_PCSrc SHALL equal i_valid & !i_flush & i_con_mem_branch & i_con_Zero, combinationally.
REQ-011 The MEM/WB register SHALL load on each rising edge when o_stall=0. While o_stall=1 it SHALL load a bubble: o_valid=0, o_con_wb_regwrite=0, other fields held.
REQ-012 o_con_wb_regwrite SHALL equal i_con_wb_regwrite & i_valid & !kill, where kill is set by i_flush or a misalignment.
REQ-013 i_flush asserted in IDLE SHALL suppress the request and load a bubble.
REQ-014 i_flush asserted at any cycle of WAIT SHALL set a sticky kill. The bus transaction SHALL complete. On ack the register SHALL load o_valid=0 and regwrite=0. The kill SHALL clear on return to IDLE.
REQ-015 A non-memory valid instruction SHALL pass through in one cycle with no stall.

Reset
REQ-016 While i_rst_n=0, the FSM SHALL be IDLE and kill SHALL be 0.
REQ-017 While i_rst_n=0, every registered output SHALL be 0, and o_dmem_req, o_stall, o_misalign and o_con_PCSrc SHALL be 0, regardless of clock.
REQ-018 Reset asserted during WAIT SHALL abandon the transaction immediately with no write-back. A late ack after reset release SHALL be ignored in IDLE when no request is live.

Verification
REQ-019 LW at 0x100, ack in the same cycle, rdata 0xDEADBEEF -> no stall; next cycle o_valid=1, o_data_Memory=0xDEADBEEF.
REQ-020 LB at 0x103, rdata 0x80FF_FFFF, ack after 3 cycles -> o_stall=1 for 3 cycles, then o_data_Memory=0xFFFF_FF80. Same access with i_unsigned=1 -> 0x0000_0080.
REQ-021 SH of 0x1234 at 0x102 -> o_dmem_be=4'b1100, o_dmem_wdata=0x1234_1234, o_dmem_we=1.
REQ-022 LH at 0x101 -> no o_dmem_req, o_misalign pulses once, o_con_wb_regwrite=0.
REQ-023 Flush asserted in the second WAIT cycle of an LW, ack in the fourth -> request held until ack, then o_valid=0 and o_con_wb_regwrite=0.
REQ-024 i_rst_n low during WAIT -> o_dmem_req and o_stall drop immediately and all outputs read 0. With DATA_W=64, LD at 0x8 returns the full 64-bit read data.
